// File: rtl/apb_pkg.sv
// Shared definitions for the APB master: FSM state encoding, bus widths and
// the slave-select values carried by request address bit 7.
package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  localparam int APB_ADDR_W = 7;
  localparam int APB_DATA_W = 8;

  localparam logic SLV1_SEL = 1'b0;
  localparam logic SLV2_SEL = 1'b1;

endpackage

// File: rtl/apb_timeout_ctr.sv
// Wait-state counter for the ACCESS phase. Expired flags the enabled cycle
// that would bring the count up to the limit.
module apb_timeout_ctr #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic         expired
);

  logic [W-1:0] count;
  logic [W:0]   next_count;

  assign next_count = {1'b0, count} + (W+1)'(1);
  assign expired    = enable && (next_count == {1'b0, limit});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= next_count[W-1:0];
    end
  end

endmodule

// File: rtl/apb_master.sv
// Two-slave APB master with a valid/ready local request port, one-cycle
// response pulse and a wait-state timeout that forces an error completion.
module apb_master
  import apb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  // Local request: accepted on any rising edge with req_valid && req_ready.
  // req_ready never depends on req_valid, so the requester may hold
  // req_valid and its payload stable until that edge.
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [7:0]            req_addr,
  input  logic [APB_DATA_W-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [APB_DATA_W-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  PSELECT1,
  output logic                  PSELECT2,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [APB_ADDR_W-1:0] PADDR,
  output logic [APB_DATA_W-1:0] PWDATA,
  input  logic [APB_DATA_W-1:0] PRDATA1,
  input  logic [APB_DATA_W-1:0] PRDATA2,
  input  logic                  PREADY1,
  input  logic                  PREADY2,
  input  logic                  PSLVERR1,
  input  logic                  PSLVERR2,
  output logic [1:0]            state_dbg
);

  localparam int CTR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CTR_W-1:0] LIMIT = CTR_W'(TIMEOUT_CYCLES);

  apb_state_e            state;
  logic                  sel;
  logic                  sel_ready;
  logic                  sel_err;
  logic [APB_DATA_W-1:0] sel_rdata;
  logic                  in_access;
  logic                  expired;
  logic                  timeout;
  logic                  accept;

  // Only the slave chosen by the captured address bit is ever observed.
  assign sel_ready = (sel == SLV2_SEL) ? PREADY2  : PREADY1;
  assign sel_err   = (sel == SLV2_SEL) ? PSLVERR2 : PSLVERR1;
  assign sel_rdata = (sel == SLV2_SEL) ? PRDATA2  : PRDATA1;

  assign in_access = (state == ST_ACCESS);
  assign timeout   = in_access && !sel_ready && expired;
  assign req_ready = (state == ST_IDLE) || (in_access && sel_ready && !timeout);
  assign accept    = req_valid && req_ready;
  assign state_dbg = state;

  apb_timeout_ctr #(.W(CTR_W)) u_timeout_ctr (
    .clk     (PCLK),
    .rst     (PRESET),
    .clear   (state == ST_SETUP),
    .enable  (in_access && !sel_ready),
    .limit   (LIMIT),
    .expired (expired)
  );

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state     <= ST_IDLE;
      sel       <= SLV1_SEL;
      PSELECT1  <= 1'b0;
      PSELECT2  <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      case (state)
        ST_IDLE: begin
        end
        ST_SETUP: begin
          state   <= ST_ACCESS;
          PENABLE <= 1'b1;
        end
        ST_ACCESS: begin
          if (timeout) begin
            state     <= ST_IDLE;
            PSELECT1  <= 1'b0;
            PSELECT2  <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
          end else if (sel_ready) begin
            state     <= ST_IDLE;
            PSELECT1  <= 1'b0;
            PSELECT2  <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= sel_err;
            rsp_rdata <= PWRITE ? '0 : sel_rdata;
          end
        end
        default: state <= ST_IDLE;
      endcase
      // A new request overrides the IDLE fall-through, giving back-to-back
      // SETUP directly after a completing ACCESS.
      if (accept) begin
        state    <= ST_SETUP;
        sel      <= req_addr[7];
        PWRITE   <= req_write;
        PADDR    <= req_addr[APB_ADDR_W-1:0];
        PWDATA   <= req_wdata;
        PSELECT1 <= (req_addr[7] == SLV1_SEL);
        PSELECT2 <= (req_addr[7] == SLV2_SEL);
        PENABLE  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Directed testbench for apb_master (TIMEOUT_CYCLES = 4); each task drives one
// scenario and checks hand-computed cycle-exact expectations.
module tb_apb_master;

  logic       PCLK = 1'b0;
  logic       PRESET;
  logic       req_valid, req_ready, req_write;
  logic [7:0] req_addr, req_wdata;
  logic       rsp_valid, rsp_err;
  logic [7:0] rsp_rdata;
  logic       PSELECT1, PSELECT2, PENABLE, PWRITE;
  logic [6:0] PADDR;
  logic [7:0] PWDATA, PRDATA1, PRDATA2;
  logic       PREADY1, PREADY2, PSLVERR1, PSLVERR2;
  logic [1:0] state_dbg;

  int errors = 0;
  int checks = 0;

  apb_master #(.TIMEOUT_CYCLES(4)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSELECT1(PSELECT1), .PSELECT2(PSELECT2), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA1(PRDATA1), .PRDATA2(PRDATA2), .PREADY1(PREADY1), .PREADY2(PREADY2),
    .PSLVERR1(PSLVERR1), .PSLVERR2(PSLVERR2), .state_dbg(state_dbg)
  );

  always #5 PCLK = ~PCLK;

  // Present a request at a negedge, let it be accepted on the next posedge
  // (edge N) and return at the negedge of cycle N+1 with req_valid dropped.
  task automatic issue(input logic wr, input logic [7:0] addr, input logic [7:0] wdata);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL issue_ready: req_ready=%b expected 1", req_ready);
    end
    @(posedge PCLK);
    @(negedge PCLK);
    req_valid = 1'b0;
  endtask

  // Observe from cycle N+1 for max_cyc cycles. rsp_cyc is the offset from N of
  // the rsp_valid pulse (-1 none, 99 duplicated). Slave PREADYs rise during
  // the raise_at-th ACCESS cycle when raise_at > 0.
  task automatic wait_rsp(input int max_cyc, input int raise_at,
                          output int en_cycles, output int sel_cycles, output int rsp_cyc,
                          output logic [7:0] rdata, output logic err, output logic rdy);
    en_cycles = 0; sel_cycles = 0; rsp_cyc = -1; rdata = 8'h00; err = 1'b0; rdy = 1'b0;
    for (int i = 1; i <= max_cyc; i++) begin
      if (PSELECT1 || PSELECT2) sel_cycles++;
      if (PENABLE) begin
        en_cycles++;
        if (en_cycles == raise_at) begin PREADY1 = 1'b1; PREADY2 = 1'b1; end
      end
      if (rsp_valid) begin
        rsp_cyc = (rsp_cyc < 0) ? i : 99;
        rdata = rsp_rdata; err = rsp_err; rdy = req_ready;
      end
      @(negedge PCLK);
    end
  endtask

  task automatic test_reset();
    PRESET = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 8'h00; req_wdata = 8'h00;
    PRDATA1 = 8'h00; PRDATA2 = 8'h00; PREADY1 = 1'b0; PREADY2 = 1'b0;
    PSLVERR1 = 1'b0; PSLVERR2 = 1'b0;
    repeat (2) @(negedge PCLK);
    checks++;
    if ({PSELECT1, PSELECT2, PENABLE, PWRITE, rsp_valid, rsp_err} !== 6'b0) begin
      errors++; $display("FAIL reset_ctl: got %b expected 000000",
                         {PSELECT1, PSELECT2, PENABLE, PWRITE, rsp_valid, rsp_err});
    end
    checks++;
    if ({PADDR, PWDATA, rsp_rdata} !== 23'h0) begin
      errors++; $display("FAIL reset_bus: paddr=%h pwdata=%h rdata=%h expected 0", PADDR, PWDATA, rsp_rdata);
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b expected 1", req_ready);
    end
    checks++;
    if (state_dbg !== 2'd0) begin
      errors++; $display("FAIL reset_state: got %0d expected 0", state_dbg);
    end
    PRESET = 1'b0;
    @(negedge PCLK);
  endtask

  task automatic test_write();
    int en, sc, rc; logic [7:0] rd; logic er, rdy;
    PREADY2 = 1'b1;
    issue(1'b1, 8'h85, 8'h3C);
    checks++;
    if ({PSELECT1, PSELECT2, PENABLE, PWRITE} !== 4'b0101) begin
      errors++; $display("FAIL write_setup: sel1,sel2,en,wr=%b expected 0101",
                         {PSELECT1, PSELECT2, PENABLE, PWRITE});
    end
    checks++;
    if (PADDR !== 7'h05 || PWDATA !== 8'h3C || state_dbg !== 2'd1) begin
      errors++; $display("FAIL write_setup_bus: paddr=%h pwdata=%h state=%0d expected 05 3c 1",
                         PADDR, PWDATA, state_dbg);
    end
    wait_rsp(8, 0, en, sc, rc, rd, er, rdy);
    checks++;
    if (sc !== 2 || en !== 1) begin
      errors++; $display("FAIL write_phases: sel=%0d en=%0d expected 2 1", sc, en);
    end
    checks++;
    if (rc !== 3 || er !== 1'b0 || rd !== 8'h00) begin
      errors++; $display("FAIL write_rsp: cyc=%0d err=%b rdata=%h expected 3 0 00", rc, er, rd);
    end
    checks++;
    if ({PSELECT1, PSELECT2, PENABLE} !== 3'b0 || PADDR !== 7'h05 || PWDATA !== 8'h3C) begin
      errors++; $display("FAIL idle_hold: sel/en=%b paddr=%h pwdata=%h expected 000 05 3c",
                         {PSELECT1, PSELECT2, PENABLE}, PADDR, PWDATA);
    end
    PREADY2 = 1'b0;
  endtask

  task automatic test_read_wait();
    int en, sc, rc; logic [7:0] rd; logic er, rdy;
    PREADY1 = 1'b0; PRDATA1 = 8'hA7;
    issue(1'b0, 8'h12, 8'h00);
    checks++;
    if (PADDR !== 7'h12 || PSELECT1 !== 1'b1 || PSELECT2 !== 1'b0 || PWRITE !== 1'b0) begin
      errors++; $display("FAIL read_setup: paddr=%h sel1=%b sel2=%b wr=%b expected 12 1 0 0",
                         PADDR, PSELECT1, PSELECT2, PWRITE);
    end
    wait_rsp(12, 4, en, sc, rc, rd, er, rdy);
    checks++;
    if (en !== 4) begin
      errors++; $display("FAIL read_enable_cycles: got %0d expected 4", en);
    end
    checks++;
    if (rc !== 6 || rd !== 8'hA7 || er !== 1'b0) begin
      errors++; $display("FAIL read_rsp: cyc=%0d rdata=%h err=%b expected 6 a7 0", rc, rd, er);
    end
    PREADY1 = 1'b0; PREADY2 = 1'b0;
  endtask

  task automatic test_back_to_back();
    PREADY1 = 1'b1; PREADY2 = 1'b1;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h01; req_wdata = 8'hAA;
    @(posedge PCLK); @(negedge PCLK);
    checks++;
    if ({PSELECT1, PSELECT2, PENABLE} !== 3'b100 || PADDR !== 7'h01) begin
      errors++; $display("FAIL b2b_setup1: sel/en=%b paddr=%h expected 100 01",
                         {PSELECT1, PSELECT2, PENABLE}, PADDR);
    end
    req_addr = 8'h81; req_wdata = 8'h55;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++; $display("FAIL b2b_setup_ready: got %b expected 0", req_ready);
    end
    @(negedge PCLK);
    checks++;
    if ({PSELECT1, PSELECT2, PENABLE} !== 3'b101 || req_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_access1: sel/en=%b ready=%b expected 101 1",
                         {PSELECT1, PSELECT2, PENABLE}, req_ready);
    end
    @(negedge PCLK);
    req_valid = 1'b0;
    checks++;
    if (state_dbg !== 2'd1 || {PSELECT1, PSELECT2, PENABLE} !== 3'b010) begin
      errors++; $display("FAIL b2b_setup2: state=%0d sel/en=%b expected 1 010",
                         state_dbg, {PSELECT1, PSELECT2, PENABLE});
    end
    checks++;
    if (PADDR !== 7'h01 || PWDATA !== 8'h55 || rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin
      errors++; $display("FAIL b2b_rsp1: paddr=%h pwdata=%h rsp=%b err=%b expected 01 55 1 0",
                         PADDR, PWDATA, rsp_valid, rsp_err);
    end
    @(negedge PCLK);
    checks++;
    if ({PSELECT1, PSELECT2, PENABLE} !== 3'b011 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_access2: sel/en=%b rsp=%b expected 011 0",
                         {PSELECT1, PSELECT2, PENABLE}, rsp_valid);
    end
    @(negedge PCLK);
    checks++;
    if (rsp_valid !== 1'b1 || {PSELECT1, PSELECT2, PENABLE} !== 3'b000 || state_dbg !== 2'd0) begin
      errors++; $display("FAIL b2b_rsp2: rsp=%b sel/en=%b state=%0d expected 1 000 0",
                         rsp_valid, {PSELECT1, PSELECT2, PENABLE}, state_dbg);
    end
    @(negedge PCLK);
    PREADY1 = 1'b0; PREADY2 = 1'b0;
  endtask

  task automatic test_timeout();
    int en, sc, rc; logic [7:0] rd; logic er, rdy;
    PREADY2 = 1'b0; PRDATA2 = 8'h5A;
    issue(1'b0, 8'h90, 8'h00);
    wait_rsp(12, 0, en, sc, rc, rd, er, rdy);
    checks++;
    if (en !== 4 || sc !== 5) begin
      errors++; $display("FAIL timeout_cycles: en=%0d sel=%0d expected 4 5", en, sc);
    end
    checks++;
    if (rc !== 6 || er !== 1'b1 || rd !== 8'h00) begin
      errors++; $display("FAIL timeout_rsp: cyc=%0d err=%b rdata=%h expected 6 1 00", rc, er, rd);
    end
    checks++;
    if (rdy !== 1'b1) begin
      errors++; $display("FAIL timeout_ready: got %b expected 1", rdy);
    end
  endtask

  task automatic test_slverr();
    int en, sc, rc; logic [7:0] rd; logic er, rdy;
    PREADY1 = 1'b1; PSLVERR1 = 1'b1; PRDATA1 = 8'h33;
    PREADY2 = 1'b0; PSLVERR2 = 1'b0; PRDATA2 = 8'hFF;
    issue(1'b0, 8'h20, 8'h00);
    wait_rsp(8, 0, en, sc, rc, rd, er, rdy);
    checks++;
    if (rc !== 3 || er !== 1'b1 || rd !== 8'h33) begin
      errors++; $display("FAIL slverr_rsp: cyc=%0d err=%b rdata=%h expected 3 1 33", rc, er, rd);
    end
    PREADY1 = 1'b0; PSLVERR1 = 1'b0;
  endtask

  task automatic test_reset_in_access();
    int en, sc, rc, stray; logic [7:0] rd; logic er, rdy;
    PREADY1 = 1'b0; PRDATA1 = 8'h4E;
    issue(1'b0, 8'h07, 8'h00);
    @(negedge PCLK);
    checks++;
    if (PENABLE !== 1'b1) begin
      errors++; $display("FAIL rst_pre_access: penable=%b expected 1", PENABLE);
    end
    PRESET = 1'b1;
    #1;
    checks++;
    if ({PSELECT1, PSELECT2, PENABLE, PWRITE, rsp_valid} !== 5'b0 || PADDR !== 7'h00 ||
        req_ready !== 1'b1 || state_dbg !== 2'd0) begin
      errors++; $display("FAIL rst_async: ctl=%b paddr=%h ready=%b state=%0d expected 00000 00 1 0",
                         {PSELECT1, PSELECT2, PENABLE, PWRITE, rsp_valid}, PADDR, req_ready, state_dbg);
    end
    @(negedge PCLK);
    PRESET = 1'b0; PREADY1 = 1'b1;
    stray = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge PCLK);
      if (rsp_valid) stray++;
    end
    checks++;
    if (stray !== 0) begin
      errors++; $display("FAIL rst_no_rsp: pulses=%0d expected 0", stray);
    end
    issue(1'b0, 8'h07, 8'h00);
    wait_rsp(8, 0, en, sc, rc, rd, er, rdy);
    checks++;
    if (rc !== 3 || rd !== 8'h4E || er !== 1'b0) begin
      errors++; $display("FAIL rst_recover: cyc=%0d rdata=%h err=%b expected 3 4e 0", rc, rd, er);
    end
    PREADY1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_back_to_back();
    test_timeout();
    test_slverr();
    test_reset_in_access();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 16, max ACCESS cycles with PREADY low before forced error termination; legal range 1..255.
REQ-002 PCLK  in  1  sole clock; all state updates on rising edge.
REQ-003 PRESET  in  1  reset, asynchronous, active-high.
REQ-004 req_valid  in  1  local request present.
REQ-005 req_ready  out  1  request accepted on the edge where req_valid && req_ready.
REQ-006 req_write  in  1  1 = write, 0 = read.
REQ-007 req_addr  in  8  bit7 selects slave (0 = slave 1, 1 = slave 2); bits 6:0 map to PADDR.
REQ-008 req_wdata  in  8  write data.
REQ-009 rsp_valid  out  1  one-cycle completion pulse.
REQ-010 rsp_rdata  out  8  read data; 0 for writes and timeouts.
REQ-011 rsp_err  out  1  selected PSLVERR at completion, or timeout.
REQ-012 PSELECT1, PSELECT2  out  1 each  APB slave selects; at most one high.
REQ-013 PENABLE  out  1; PWRITE  out  1; PADDR  out  7; PWDATA  out  8  APB request bus.
REQ-014 PRDATA1, PRDATA2  in  8; PREADY1, PREADY2  in  1; PSLVERR1, PSLVERR2  in  1  per-slave response inputs.

Function
REQ-015 FSM states IDLE, SETUP, ACCESS shall be implemented; IDLE is the reset state.
REQ-016 req_ready = (state==IDLE) || (state==ACCESS && selected PREADY high && no timeout in this cycle), combinational.
REQ-017 On acceptance, req_write, req_addr and req_wdata shall be captured and the FSM shall enter SETUP.
REQ-018 SETUP: selected PSELECTx=1, PENABLE=0; always ACCESS next cycle.
REQ-019 ACCESS: PSELECTx=1, PENABLE=1; PADDR, PWRITE, PWDATA unchanged from SETUP until exit.
REQ-020 ACCESS with selected PREADY=1 completes: next cycle rsp_valid=1, rsp_err=selected PSLVERR, rsp_rdata=selected PRDATA for reads (0 for writes).
REQ-021 On completion the FSM shall go to SETUP if a new request is accepted in the same cycle (back-to-back), else IDLE.
REQ-022 Wait counter: clears on SETUP entry; increments each ACCESS cycle with selected PREADY=0.
REQ-023 When the counter reaches TIMEOUT_CYCLES while PREADY is still low: terminate, go IDLE, next cycle rsp_valid=1, rsp_err=1, rsp_rdata=0.
REQ-024 Response inputs of the unselected slave shall be ignored; selection shall use the captured addr bit7.
REQ-025 In IDLE: PSELECT1=PSELECT2=PENABLE=0; PADDR, PWRITE, PWDATA hold their last values.
REQ-026 Minimum latency with a zero-wait slave: accept edge N, SETUP in cycle N+1, ACCESS in N+2, rsp_valid in N+3.
REQ-027 rsp_valid shall be high for exactly one cycle per accepted request; responses are never dropped or duplicated.

Reset
REQ-028 PRESET high shall immediately force state IDLE, counter 0, and all outputs 0 except req_ready=1.
REQ-029 Reset during SETUP or ACCESS abandons the transfer; no rsp_valid is issued for it.

Structure
REQ-030 Shared package apb_pkg: state enum, APB_ADDR_W=7, APB_DATA_W=8, slave-select index constants.
REQ-031 Wait counter shall be a sub-module apb_timeout_ctr (clear, enable, limit, expired); width $clog2(TIMEOUT_CYCLES+1).

Verification
REQ-032 Write 0x85 <- 0x3C, slave 2 PREADY tied 1: PSELECT2 high for 2 cycles, PADDR=0x05, PWDATA=0x3C; rsp_valid at N+3 with rsp_err=0.
REQ-033 Read 0x12, slave 1 returns 0xA7 after 3 wait cycles: PENABLE high 4 cycles; rsp_rdata=0xA7.
REQ-034 Back-to-back writes 0x01 then 0x81, req_valid held: SETUP follows ACCESS directly; PSELECT1 then PSELECT2 with no IDLE cycle.
REQ-035 Slave 2 PREADY stuck 0, TIMEOUT_CYCLES=4: exit after 4 wait cycles; rsp_err=1, rsp_rdata=0; req_ready high next cycle.
REQ-036 PSLVERR1=1 with PREADY1=1 on read: rsp_err=1; PRDATA2=0xFF and PSLVERR2=0 held throughout are ignored.
REQ-037 PRESET asserted in ACCESS: outputs 0 immediately; no rsp_valid; next request completes normally.
